sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 94 +++++++++
 tb/tb_sdram_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of a single SDRAM controller port.
// Fixed priority 0 > 1 > 2, with a starvation counter that forces the CPU port in after STARVE_MAX losses.
module sdram_port_arbiter #(
  parameter int AW         = 24,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic [1:0]      grant,
  output logic            busy,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] starve;
  logic [1:0]    win;

  // Port 2 jumps the queue once it has lost STARVE_MAX arbitrations in a row.
  always_comb begin
    win = 2'd3;
    if (starve == STARVE_LIM && req[2]) win = 2'd2;
    else if (req[0])                    win = 2'd0;
    else if (req[1])                    win = 2'd1;
    else if (req[2])                    win = 2'd2;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req)   state_nxt = BUSY;
      BUSY:    if (mem_ack) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    mem_req = (state == BUSY);
    ack     = (state == DONE) ? 3'(3'b001 << grant) : 3'b000;
  end

  // The mem_* payload is captured only at arbitration, so later activity on the
  // request ports cannot disturb an access in flight.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= 2'd3;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      starve    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant     <= win;
            mem_we    <= we[win];
            mem_addr  <= addr[win*AW +: AW];
            mem_wdata <= wdata[win*DW +: DW];
            if (win == 2'd2 || !req[2]) starve <= '0;
            else                        starve <= starve + 1'b1;
          end
        end
        BUSY: if (mem_ack) rdata <= mem_rdata;
        DONE: grant <= 2'd3;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: table of request vectors plus hand-written corner sequences,
// with an SDRAM responder model and a scoreboard of expected completions.
module tb_sdram_port_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;

  logic            clk_sys = 1'b0;
  logic            rst_n   = 1'b0;
  logic [2:0]      req     = '0;
  logic [2:0]      we      = '0;
  logic [3*AW-1:0] addr    = '0;
  logic [3*DW-1:0] wdata   = '0;
  logic [2:0]      ack;
  logic [DW-1:0]   rdata;
  logic [1:0]      grant;
  logic            busy, mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ack   = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;

  sdram_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .grant(grant), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] rd;
    int            starve;
  } exp_t;

  typedef struct {
    string         name;
    logic [2:0]    req;
    logic [2:0]    we;
    logic [AW-1:0] a0, a1, a2;
    logic [DW-1:0] d0, d1, d2;
    int            dly;
    logic [5:0]    ord;
    int            cyc;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  int            errors = 0, checks = 0;
  int            resp_dly = 0, cnt = 0;
  bit            resp_en = 1'b1, in_flight = 1'b0, stable_bad = 1'b0, toggle = 1'b0;
  logic [2:0]    drop_mask = 3'b111;
  logic [AW-1:0] snap_a = '0, last_a = '0;
  logic          snap_we = 1'b0, last_we = 1'b0;
  logic [DW-1:0] snap_d = '0, last_d = '0, r0;

  function automatic logic [DW-1:0] rd_val(logic [AW-1:0] a);
    return a[15:0] ^ 16'hACDB;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void push(int p, int st);
    exp_t e;
    e.port   = p;
    e.we     = we[p];
    e.a      = addr[p*AW +: AW];
    e.d      = wdata[p*DW +: DW];
    e.rd     = rd_val(e.a);
    e.starve = st;
    sb.push_back(e);
  endfunction

  // One cycle: observe outputs at the falling edge, then model the SDRAM side and requesters.
  task automatic tick();
    exp_t e;
    @(negedge clk_sys);
    if (ack != 3'b000) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got %b expected 000 at %0t", ack, $time);
      end else begin
        e = sb.pop_front();
        chk("ack", 32'(ack), 32'(3'b001 << e.port));
        chk("grant", 32'(grant), 32'(e.port));
        chk("mem_addr", 32'(last_a), 32'(e.a));
        chk("mem_we", 32'(last_we), 32'(e.we));
        if (e.we) chk("mem_wdata", 32'(last_d), 32'(e.d));
        else      chk("rdata", 32'(rdata), 32'(e.rd));
        chk("mem_hold", 32'(stable_bad), 32'd0);
        if (e.starve >= 0) chk("starve", 32'(dut.starve), 32'(e.starve));
      end
      for (int p = 0; p < 3; p++) if (ack[p] && drop_mask[p]) req[p] = 1'b0;
    end
    if (mem_req) begin
      if (!in_flight) begin
        in_flight = 1'b1; stable_bad = 1'b0; cnt = 0;
        snap_a = mem_addr; snap_we = mem_we; snap_d = mem_wdata;
      end else if (mem_addr !== snap_a || mem_we !== snap_we || mem_wdata !== snap_d) begin
        stable_bad = 1'b1;
      end
      cnt++;
    end
    mem_ack = 1'b0;
    if (mem_req && resp_en && cnt == resp_dly + 1) begin
      mem_ack   = 1'b1;
      mem_rdata = rd_val(snap_a);
      last_a = snap_a; last_we = snap_we; last_d = snap_d;
      in_flight = 1'b0;
    end
    if (toggle) begin
      addr[0 +: AW]    = AW'($urandom);
      wdata[0 +: DW]   = DW'($urandom);
      addr[2*AW +: AW] = AW'($urandom);
      we[0]            = ~we[0];
    end
  endtask

  task automatic run(string nm, int exp_cyc);
    int k = 0;
    while (k < 200 && !(sb.size() == 0 && !busy)) begin
      tick();
      k++;
      if (nm == "starve" && sb.size() <= 1) drop_mask = 3'b101;
    end
    chk({nm, "_cycles"}, 32'(k), 32'(exp_cyc));
    chk({nm, "_grant_idle"}, 32'(grant), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"rd_single", 3'b100, 3'b000, 24'h000000, 24'h000000, 24'h001234,
                16'h0, 16'h0, 16'h0, 2, 6'b00_00_10, 5};
    vecs[1] = '{"simul", 3'b111, 3'b000, 24'h000100, 24'h000200, 24'h000300,
                16'h0, 16'h0, 16'h0, 0, 6'b10_01_00, 9};
    vecs[2] = '{"wr_p1", 3'b010, 3'b010, 24'h000000, 24'h000010, 24'h000000,
                16'h0, 16'h5A5A, 16'h0, 1, 6'b00_00_01, 4};
    vecs[3] = '{"wr0_rd1", 3'b011, 3'b001, 24'hFFFFFF, 24'h000000, 24'h000000,
                16'hFFFF, 16'h0, 16'h0, 3, 6'b00_01_00, 12};
    vecs[4] = '{"rd1_wr2", 3'b110, 3'b100, 24'h000000, 24'hABCDEF, 24'h000020,
                16'h0, 16'h0, 16'h8001, 0, 6'b00_10_01, 6};

    // Reset state
    repeat (2) @(negedge clk_sys);
    chk("rst_grant", 32'(grant), 32'd3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;

    // Spurious mem_ack while idle
    tick();
    r0 = rdata;
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    chk("spur_ack", 32'(ack), 32'd0);
    chk("spur_busy", 32'(busy), 32'd0);
    tick();
    chk("spur_rdata", 32'(rdata), 32'(r0));
    chk("spur_busy2", 32'(busy), 32'd0);

    // Table of request vectors
    for (int i = 0; i < 5; i++) begin
      req = vecs[i].req; we = vecs[i].we;
      addr  = {vecs[i].a2, vecs[i].a1, vecs[i].a0};
      wdata = {vecs[i].d2, vecs[i].d1, vecs[i].d0};
      resp_dly = vecs[i].dly; drop_mask = 3'b111;
      for (int k = 0; k < $countones(vecs[i].req); k++) push(int'(vecs[i].ord[2*k +: 2]), -1);
      run(vecs[i].name, vecs[i].cyc);
    end

    // Starvation: port 0 keeps re-requesting while port 2 waits
    req = 3'b101; we = 3'b000; resp_dly = 0; drop_mask = 3'b100;
    addr = {24'h000080, 24'h000000, 24'h000040};
    push(0, 1); push(0, 2); push(0, 3); push(0, 4); push(2, 0); push(0, 0);
    run("starve", 18);

    // Port 1 write while port 0/2 payloads churn
    drop_mask = 3'b111; resp_dly = 3;
    req = 3'b010; we = 3'b010;
    addr[AW +: AW] = 24'h000010; wdata[DW +: DW] = 16'h5A5A;
    push(1, -1);
    toggle = 1'b1;
    run("wr_hold", 6);
    toggle = 1'b0;

    // Reset in the middle of an access
    resp_en = 1'b0; resp_dly = 0;
    req = 3'b010; we = 3'b000; addr[AW +: AW] = 24'h000777;
    tick();
    chk("rst_mid_req_up", 32'(mem_req), 32'd1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_grant", 32'(grant), 32'd3);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ack", 32'(ack), 32'd0);
    tick();
    tick();
    in_flight = 1'b0; cnt = 0; resp_en = 1'b1;
    rst_n = 1'b1;
    push(1, -1);
    run("rst_recover", 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
